// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and types for the instruction-fetch stage
package fetch_pkg;

  localparam int DEF_N    = 16;
  localparam int DEF_PC_W = 16;

  // Architectural no-op: no register write, no memory write, no PC write.
  localparam logic [15:0] NOP_INSTR = 16'hB000;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// rtl/fetch_skid_buffer.sv - one-entry {instr, pc} holding register for data returned during a stall
module fetch_skid_buffer #(
  parameter int N    = 16,
  parameter int PC_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            capture,
  input  logic            drain,
  input  logic            flush,
  input  logic [N-1:0]    in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic [N-1:0]    instr,
  output logic [PC_W-1:0] pc,
  output logic            valid
);

  // Flush beats capture so a redirect never leaves a stale entry behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= '0;
      pc    <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (capture) begin
      instr <= in_instr;
      pc    <= in_pc;
      valid <= 1'b1;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC, 1-cycle imem request tracking and IF/ID register; FETCH_PERF_CNT_EN adds fetch/bubble counters
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              N        = DEF_N,
  parameter int              PC_W     = DEF_PC_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  output logic [PC_W-1:0] imem_addr,
  input  logic [N-1:0]    imem_rdata,
  output logic [N-1:0]    instr_out,
  output logic [PC_W-1:0] pc_out,
  output logic            instr_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]     fetch_count,
  output logic [15:0]     bubble_count
`endif
);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_fetch_q;
  logic [PC_W-1:0] req_pc_q;
  logic            req_valid_q;

  logic            advance;
  logic            capture;
  logic            flush;

  logic [N-1:0]    skid_instr;
  logic [PC_W-1:0] skid_pc;
  logic            skid_valid;

  logic [N-1:0]    load_instr;
  logic [PC_W-1:0] load_pc;
  logic            load_valid;

  assign imem_addr = pc_fetch_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FILL;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    advance = 1'b0;
    capture = 1'b0;
    flush   = 1'b0;
    if (branch_taken) begin
      flush   = 1'b1;
      state_d = RUN;
    end else if (stall) begin
      capture = req_valid_q;
      if (state_q != FILL) state_d = HOLD;
    end else begin
      advance = 1'b1;
      state_d = RUN;
    end
  end

  // Skid data is always older than anything in flight, so it drains first.
  always_comb begin
    load_instr = N'(NOP_INSTR);
    load_pc    = '0;
    load_valid = 1'b0;
    if (skid_valid) begin
      load_instr = skid_instr;
      load_pc    = skid_pc;
      load_valid = 1'b1;
    end else if (req_valid_q) begin
      load_instr = imem_rdata;
      load_pc    = req_pc_q;
      load_valid = 1'b1;
    end
  end

  fetch_skid_buffer #(.N(N), .PC_W(PC_W)) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .capture  (capture),
    .drain    (advance),
    .flush    (flush),
    .in_instr (imem_rdata),
    .in_pc    (req_pc_q),
    .instr    (skid_instr),
    .pc       (skid_pc),
    .valid    (skid_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_fetch_q  <= RESET_PC;
      req_pc_q    <= '0;
      req_valid_q <= 1'b0;
      instr_out   <= N'(NOP_INSTR);
      pc_out      <= '0;
      instr_valid <= 1'b0;
    end else if (flush) begin
      pc_fetch_q  <= branch_target;
      req_valid_q <= 1'b0;
      instr_out   <= N'(NOP_INSTR);
      pc_out      <= '0;
      instr_valid <= 1'b0;
    end else if (advance) begin
      req_pc_q    <= pc_fetch_q;
      req_valid_q <= 1'b1;
      pc_fetch_q  <= pc_fetch_q + PC_W'(1);
      instr_out   <= load_instr;
      pc_out      <= load_pc;
      instr_valid <= load_valid;
    end else if (capture) begin
      req_valid_q <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Stalled edges leave IF/ID untouched and are counted as neither.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count  <= '0;
      bubble_count <= '0;
    end else if (flush) begin
      bubble_count <= bubble_count + 16'd1;
    end else if (advance) begin
      if (load_valid) fetch_count  <= fetch_count + 16'd1;
      else            bubble_count <= bubble_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - vector-table bench for fetch_stage with a mem[a] = 16'h1000 + a instruction memory
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic [15:0] instr_out;
  logic [15:0] pc_out;
  logic        instr_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_count;
  logic [15:0] bubble_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .instr_out     (instr_out),
    .pc_out        (pc_out),
    .instr_valid   (instr_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count   (fetch_count),
    .bubble_count  (bubble_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory, one cycle latency.
  always @(posedge clk) imem_rdata <= 16'h1000 + imem_addr;

  typedef struct {
    logic        stall;
    logic        br;
    logic [15:0] tgt;
    logic [15:0] e_instr;
    logic [15:0] e_pc;
    logic        e_valid;
    logic [15:0] e_addr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic s, input logic b, input logic [15:0] t,
                     input logic [15:0] ei, input logic [15:0] ep,
                     input logic ev, input logic [15:0] ea);
    vec_t v;
    v.stall = s; v.br = b; v.tgt = t;
    v.e_instr = ei; v.e_pc = ep; v.e_valid = ev; v.e_addr = ea;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [15:0] ei, input logic [15:0] ep,
                            input logic ev, input logic [15:0] ea);
    check({tag, " instr"}, 32'(instr_out), 32'(ei));
    check({tag, " pc"},    32'(pc_out),    32'(ep));
    check({tag, " valid"}, 32'(instr_valid), 32'(ev));
    check({tag, " addr"},  32'(imem_addr), 32'(ea));
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;

    //  stall br  tgt       instr    pc       v  addr
    add(0, 0, 16'h0000, 16'hB000, 16'h0000, 0, 16'h0001); // fill bubble
    add(0, 0, 16'h0000, 16'h1000, 16'h0000, 1, 16'h0002);
    add(0, 0, 16'h0000, 16'h1001, 16'h0001, 1, 16'h0003);
    add(0, 0, 16'h0000, 16'h1002, 16'h0002, 1, 16'h0004);
    add(0, 0, 16'h0000, 16'h1003, 16'h0003, 1, 16'h0005);
    add(0, 0, 16'h0000, 16'h1004, 16'h0004, 1, 16'h0006);
    add(1, 0, 16'h0000, 16'h1004, 16'h0004, 1, 16'h0006); // stall x3
    add(1, 0, 16'h0000, 16'h1004, 16'h0004, 1, 16'h0006);
    add(1, 0, 16'h0000, 16'h1004, 16'h0004, 1, 16'h0006);
    add(0, 0, 16'h0000, 16'h1005, 16'h0005, 1, 16'h0007); // skid drains
    add(0, 0, 16'h0000, 16'h1006, 16'h0006, 1, 16'h0008);
    add(0, 0, 16'h0000, 16'h1007, 16'h0007, 1, 16'h0009);
    add(0, 1, 16'h0040, 16'hB000, 16'h0000, 0, 16'h0040); // branch
    add(0, 0, 16'h0000, 16'hB000, 16'h0000, 0, 16'h0041);
    add(0, 0, 16'h0000, 16'h1040, 16'h0040, 1, 16'h0042);
    add(0, 0, 16'h0000, 16'h1041, 16'h0041, 1, 16'h0043);
    add(1, 1, 16'h0080, 16'hB000, 16'h0000, 0, 16'h0080); // branch + stall
    add(1, 0, 16'h0000, 16'hB000, 16'h0000, 0, 16'h0080);
    add(1, 0, 16'h0000, 16'hB000, 16'h0000, 0, 16'h0080);
    add(0, 0, 16'h0000, 16'hB000, 16'h0000, 0, 16'h0081);
    add(0, 0, 16'h0000, 16'h1080, 16'h0080, 1, 16'h0082);
    add(0, 1, 16'hFFFE, 16'hB000, 16'h0000, 0, 16'hFFFE); // wrap
    add(0, 0, 16'h0000, 16'hB000, 16'h0000, 0, 16'hFFFF);
    add(0, 0, 16'h0000, 16'h0FFE, 16'hFFFE, 1, 16'h0000);
    add(0, 0, 16'h0000, 16'h0FFF, 16'hFFFF, 1, 16'h0001);
    add(0, 0, 16'h0000, 16'h1000, 16'h0000, 1, 16'h0002);
    add(1, 0, 16'h0000, 16'h1000, 16'h0000, 1, 16'h0002); // into HOLD
    add(1, 0, 16'h0000, 16'h1000, 16'h0000, 1, 16'h0002);

    repeat (3) @(posedge clk);
    #1;
    check_outs("reset", 16'hB000, 16'h0000, 1'b0, 16'h0000);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      stall         = vecs[i].stall;
      branch_taken  = vecs[i].br;
      branch_target = vecs[i].tgt;
      @(posedge clk);
      #1;
      check_outs($sformatf("v%0d", i), vecs[i].e_instr, vecs[i].e_pc,
                 vecs[i].e_valid, vecs[i].e_addr);
      branch_taken = 1'b0;
    end

`ifdef FETCH_PERF_CNT_EN
    check("fetch_count", 32'(fetch_count), 32'd14);
    check("bubble_count", 32'(bubble_count), 32'd7);
`endif

    // Asynchronous reset while in HOLD with a captured skid entry.
    #1 rst_n = 1'b0;
    #1;
    check_outs("midreset", 16'hB000, 16'h0000, 1'b0, 16'h0000);
`ifdef FETCH_PERF_CNT_EN
    check("midreset fetch_count", 32'(fetch_count), 32'd0);
    check("midreset bubble_count", 32'(bubble_count), 32'd0);
`endif
    stall = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check_outs("restart1", 16'hB000, 16'h0000, 1'b0, 16'h0001);
    @(posedge clk); #1;
    check_outs("restart2", 16'h1000, 16'h0000, 1'b1, 16'h0002);
    @(posedge clk); #1;
    check_outs("restart3", 16'h1001, 16'h0001, 1'b1, 16'h0003);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the decode stage.
- Owns the program counter and drives a synchronous-read instruction memory with 1-cycle read latency.
- Holds the IF/ID pipeline register that feeds the decoder's 16-bit instruction input.
- Handles pipeline stall, and branch redirect/flush from execute; inserts the architectural NOP on bubbles because the decoder has no valid input.

Parameters:
- N, 16, instruction width.
- PC_W, 16, program-counter width; word-addressed, so PC increments by 1.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  hold request from a downstream hazard unit.
- branch_taken  in  1  redirect request from execute, single-cycle pulse.
- branch_target  in  PC_W  redirect address, valid with branch_taken.
- imem_addr  out  PC_W  instruction-memory read address; equals pc_fetch_q combinationally.
- imem_rdata  in  N  read data for the address presented on the previous cycle.
- instr_out  out  N  IF/ID instruction; drives the decoder instruction input.
- pc_out  out  PC_W  PC of instr_out.
- instr_valid  out  1  1 when instr_out is a real fetched instruction.

Behaviour:
- NOP_INSTR is 16'hB000: decodes to no register write, no memory write and PcWriteEn = 0.
- Reset (async assert, sync-release use):
  - pc_fetch_q = RESET_PC; req_valid_q = 0; skid_valid_q = 0.
  - instr_out = NOP_INSTR; pc_out = 0; instr_valid = 0; state = FILL.
- Request tracking:
  - req_valid_q and req_pc_q mark that imem_rdata on the current cycle belongs to req_pc_q.
- Normal edge (no stall, no branch):
  - req_pc_q <= pc_fetch_q; req_valid_q <= 1; pc_fetch_q <= pc_fetch_q + 1 (wraps modulo 2^PC_W).
  - IF/ID loads {imem_rdata, req_pc_q, 1} if req_valid_q, else {NOP_INSTR, 0, 0}.
- Latency:
  - Address to instr_out is 2 edges.
  - First valid instruction after reset release appears on the 2nd edge.
- States:
  - FILL: no request in flight. Goes to RUN on the first non-stalled edge.
  - RUN: steady fetch. Goes to HOLD on an edge where stall = 1.
  - HOLD: IF/ID and pc_fetch_q frozen. Goes to RUN on the first edge with stall = 0.
- Entering HOLD:
  - If req_valid_q = 1, capture {imem_rdata, req_pc_q} into the skid register; skid_valid_q <= 1; req_valid_q <= 0.
  - Data is never dropped.
- Leaving HOLD (stall = 0 edge):
  - If skid_valid_q = 1, IF/ID loads the skid contents (valid = 1) and skid_valid_q <= 0.
  - Simultaneously issue pc_fetch_q as a normal request.
  - Result: the instruction stream stays contiguous, with no duplicate and no gap.
- Branch redirect (branch_taken = 1 on an edge, any state, priority over stall):
  - pc_fetch_q <= branch_target; req_valid_q <= 0; skid_valid_q <= 0.
  - IF/ID <= {NOP_INSTR, 0, 0}; state <= RUN.
  - Target instruction reaches instr_out 2 edges later (2 bubbles).
- Reset asserted mid-operation: all state returns immediately to reset values; any in-flight request is discarded.
- stall held for many cycles: outputs stay constant; imem_addr stays constant.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, adds two output ports, both 16-bit, reset to 0, wrapping:
  - fetch_count: increments on each edge where IF/ID loads with valid = 1.
  - bubble_count: increments on each edge where IF/ID loads NOP_INSTR, whether from a flush or an empty pipe; HOLD edges are not counted.
- When undefined, the ports and counters are absent; functional behaviour is identical.

Decomposition:
- Package fetch_pkg holds:
  - NOP_INSTR.
  - Default PC_W and N.
  - Enum fetch_state_t {FILL, RUN, HOLD}.
- One sub-module: fetch_skid_buffer.
  - One-entry {instr, pc} register with capture, drain and flush inputs, and a valid output.
  - Instantiated once.

Test Plan:
- Reset release, memory returning mem[a] = 16'h1000 + a:
  - instr_out = 16'h1000, pc_out = 0, valid = 1 on edge 2.
  - Then 16'h1001 and 16'h1002 on consecutive edges.
- stall high for 3 cycles while pc_out = 4:
  - instr_out holds 16'h1004 during the stall.
  - After release, the sequence 16'h1005, 16'h1006 follows with no skip or repeat.
  - imem_addr is constant during the stall.
- branch_taken with target 16'h0040 at pc_out = 7:
  - Next 2 edges give instr_out = 16'hB000, valid = 0.
  - Then 16'h1040 with pc_out = 16'h0040.
- branch_taken and stall high on the same edge:
  - Branch wins; skid cleared; target fetched once stall drops.
  - No stale 16'h100x appears.
- Wrap-around: branch to 16'hFFFE:
  - pc_out sequence is FFFE, FFFF, 0000.
- rst_n pulsed low mid-stream during HOLD:
  - Outputs are immediately NOP, 0, 0.
  - Restart from RESET_PC after 2 edges.
  - With FETCH_PERF_CNT_EN defined, both counters read 0.
